// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan driver: digit indices,
// active-low segment patterns, anode patterns and a BCD validity helper.
package seg7_pkg;

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_t;

  // Segment order is {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic any_invalid(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_seg7_scan_if.sv
// Display-side bundle: packed BCD load path in, common-anode drive and error flag out.
interface bcd_seg7_scan_if;
  logic [15:0] P;
  logic        load;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err;

  modport master (output P, load, blank_lz, input an, seg, dp, err);
  modport slave  (input P, load, blank_lz, output an, seg, dp, err);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-BCD codes show "E".
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 4-digit common-anode driver with load strobe,
// leading-zero blanking and an invalid-digit flag.
module bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            reset,
  bcd_seg7_scan_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [15:0]   disp_q, disp_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  digit_t        idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic [3:0]    zero;
  logic          blank;

  always_comb begin
    disp_d = bus.load ? bus.P : disp_q;
    err_d  = any_invalid(disp_d);
    tick   = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    idx_d  = tick ? digit_t'(idx_q + 2'd1) : idx_q;
  end

  always_comb begin
    nib = disp_q[3:0];
    case (idx_q)
      D0: nib = disp_q[3:0];
      D1: nib = disp_q[7:4];
      D2: nib = disp_q[11:8];
      D3: nib = disp_q[15:12];
      default: nib = disp_q[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // A nibble above 9 is not zero, so it stops blanking of itself and lower digits.
  always_comb begin
    for (int i = 0; i < 4; i++) zero[i] = (disp_q[i*4 +: 4] == 4'd0);
    blank = 1'b0;
    case (idx_q)
      D0: blank = 1'b0;
      D1: blank = bus.blank_lz & zero[3] & zero[2] & zero[1];
      D2: blank = bus.blank_lz & zero[3] & zero[2];
      D3: blank = bus.blank_lz & zero[3];
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (!blank) begin
      seg_d = dec_seg;
      case (idx_q)
        D0: an_d = AN_D0;
        D1: an_d = AN_D1;
        D2: an_d = AN_D2;
        D3: an_d = AN_D3;
        default: an_d = AN_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= D0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      disp_q <= disp_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.err = err_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed bench for bcd_seg7_scan with a cycle model feeding an expected-output queue.
module tb_bcd_seg7_scan;
  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic reset;
  bcd_seg7_scan_if bus();

  bcd_seg7_scan #(.REFRESH_DIV(RDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] tbl [16];

  // Reference model state
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_disp;
  logic        m_err;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_disp = 16'h0000; m_err = 1'b0;
  endtask

  // Called at a negedge: drive, predict next edge, run the edge, compare.
  task automatic step(input logic ld, input logic [15:0] p, input logic blz, input string tag);
    exp_t e;
    logic [3:0] nibv;
    logic allz;
    exp_t got;
    bus.load = ld; bus.P = p; bus.blank_lz = blz;
    nibv = 4'((m_disp >> (4 * m_idx)) & 16'hF);
    allz = 1'b1;
    for (int k = m_idx; k < 4; k++) if (((m_disp >> (4 * k)) & 16'hF) != 0) allz = 1'b0;
    if (blz && m_idx > 0 && allz) begin
      e.an = 4'b1111; e.seg = 7'b1111111;
    end else begin
      e.an = ~(4'b0001 << m_idx); e.seg = tbl[nibv];
    end
    if (ld) m_disp = p;
    m_err = 1'b0;
    for (int k = 0; k < 4; k++) if (((m_disp >> (4 * k)) & 16'hF) > 9) m_err = 1'b1;
    if (m_cnt == RDIV - 1) begin
      m_cnt = 0; m_idx = (m_idx + 1) % 4;
    end else m_cnt = m_cnt + 1;
    e.err = m_err;
    q.push_back(e);
    @(posedge clk); #1;
    got = q.pop_front();
    check({tag, ".an"},  {12'h0, bus.an},  {12'h0, got.an});
    check({tag, ".seg"}, {9'h0, bus.seg},  {9'h0, got.seg});
    check({tag, ".err"}, {15'h0, bus.err}, {15'h0, got.err});
    check({tag, ".dp"},  {15'h0, bus.dp},  16'h0001);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    tbl[0] = 7'b0000001; tbl[1] = 7'b1001111; tbl[2] = 7'b0010010; tbl[3] = 7'b0000110;
    tbl[4] = 7'b1001100; tbl[5] = 7'b0100100; tbl[6] = 7'b0100000; tbl[7] = 7'b0001111;
    tbl[8] = 7'b0000000; tbl[9] = 7'b0000100;
    for (int k = 10; k < 16; k++) tbl[k] = 7'b0110000;

    reset = 1'b1; bus.P = 16'h0; bus.load = 1'b0; bus.blank_lz = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.an",  {12'h0, bus.an},  16'h000F);
    check("rst.seg", {9'h0, bus.seg},  16'h007F);
    check("rst.err", {15'h0, bus.err}, 16'h0000);
    check("rst.dp",  {15'h0, bus.dp},  16'h0001);

    @(negedge clk); reset = 1'b0;
    step(1'b0, 16'h0, 1'b0, "first");
    check("first.an_c",  {12'h0, bus.an}, 16'h000E);
    check("first.seg_c", {9'h0, bus.seg}, 16'h0001);
    step(1'b0, 16'h0, 1'b0, "idle");

    // Full scan of 1234
    step(1'b1, 16'h1234, 1'b0, "scan_ld");
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 1'b0, "scan");

    // Leading-zero blanking
    step(1'b1, 16'h0010, 1'b1, "blz_ld");
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, "blz10");
    step(1'b1, 16'h0000, 1'b1, "blz0_ld");
    for (int i = 0; i < 16; i++) step(1'b0, 16'hFFFF, 1'b1, "blz0");

    // Invalid digit flag and its recovery
    step(1'b1, 16'h0A05, 1'b1, "inv_ld");
    check("inv.err_c", {15'h0, bus.err}, 16'h0001);
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b1, "inv");
    step(1'b1, 16'h0005, 1'b1, "inv_clr");
    check("inv_clr.err_c", {15'h0, bus.err}, 16'h0000);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, "inv_clr");

    // Load pulse in the middle of D1's dwell
    guard = 0;
    while (!(m_idx == 1 && m_cnt == 1) && guard < 20) begin
      step(1'b0, 16'h0000, 1'b0, "sync_d1");
      guard++;
    end
    check("sync_d1.bound", 16'(guard < 20), 16'h0001);
    step(1'b1, 16'h0090, 1'b0, "mid_ld");
    for (int i = 0; i < 12; i++) step(1'b0, 16'h1111, 1'b0, "mid");

    // Asynchronous reset during D2
    guard = 0;
    while (!(m_idx == 2 && m_cnt == 1) && guard < 20) begin
      step(1'b1, 16'h0B07, 1'b0, "sync_d2");
      guard++;
    end
    check("sync_d2.bound", 16'(guard < 20), 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("arst.an",  {12'h0, bus.an},  16'h000F);
    check("arst.seg", {9'h0, bus.seg},  16'h007F);
    check("arst.err", {15'h0, bus.err}, 16'h0000);
    model_reset();
    @(negedge clk); reset = 1'b0;
    step(1'b0, 16'h0000, 1'b1, "post_rst");
    check("post_rst.an_c",  {12'h0, bus.an}, 16'h000E);
    check("post_rst.seg_c", {9'h0, bus.seg}, 16'h0001);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
